// File: rtl/interrupt_controller.sv
// 8051-style interrupt controller: pin synchronisation, IE/IP masking,
// two-level priority arbitration, vectored request and in-service tracking.
module interrupt_controller #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [15:0] VEC_BASE    = 16'h0003,
  parameter logic [15:0] VEC_STRIDE  = 16'h0008
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [7:0]  i_ie,
  input  logic [7:0]  i_ip,
  input  logic        i_it0,
  input  logic        i_it1,
  input  logic        i_int0_n,
  input  logic        i_int1_n,
  input  logic        i_ie0_clr,
  input  logic        i_ie1_clr,
  input  logic        i_tf0,
  input  logic        i_tf1,
  input  logic        i_ri,
  input  logic        i_ti,
  input  logic        i_ack,
  input  logic        i_reti,
  output logic        o_irq,
  output logic [15:0] o_vector,
  output logic        o_ie0,
  output logic        o_ie1,
  output logic        o_tf0_clr,
  output logic        o_tf1_clr,
  output logic [1:0]  o_in_service
);

  localparam int unsigned NSRC  = 5;
  localparam int unsigned IDX_W = 3;

  typedef enum logic {IDLE, REQ} state_t;

  state_t             state_q, state_d;
  logic               irq_q, irq_d;
  logic [15:0]        vec_q, vec_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [1:0]         ins_q, ins_d, ins_ret;
  logic               tf0_clr_q, tf0_clr_d;
  logic               tf1_clr_q, tf1_clr_d;
  logic               ack_ie0_c, ack_ie1_c;

  logic [SYNC_STAGES-1:0] sync0_q, sync1_q;
  logic               prev0_q, prev1_q;
  logic               ie0_q, ie1_q;
  logic               pin0_s, pin1_s;

  logic [NSRC-1:0]    flags, req_ok, req_hi, req_lo, pick;
  logic [NSRC-1:0]    lvl_mask;
  logic               any_req;
  logic [IDX_W-1:0]   win_idx;
  logic [15:0]        win_vec;
  logic               unused_bits;

  assign unused_bits = &{1'b0, i_ie[6:5]};

  assign pin0_s = sync0_q[SYNC_STAGES-1];
  assign pin1_s = sync1_q[SYNC_STAGES-1];

  // Pin synchronisers, edge history and IE0/IE1 flags (set wins over clear)
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync0_q <= '1;
      sync1_q <= '1;
      prev0_q <= 1'b1;
      prev1_q <= 1'b1;
      ie0_q   <= 1'b0;
      ie1_q   <= 1'b0;
    end else begin
      sync0_q <= {sync0_q[SYNC_STAGES-2:0], i_int0_n};
      sync1_q <= {sync1_q[SYNC_STAGES-2:0], i_int1_n};
      prev0_q <= pin0_s;
      prev1_q <= pin1_s;
      if (i_it0) ie0_q <= (prev0_q & ~pin0_s) | (ie0_q & ~(i_ie0_clr | ack_ie0_c));
      else       ie0_q <= ~pin0_s;
      if (i_it1) ie1_q <= (prev1_q & ~pin1_s) | (ie1_q & ~(i_ie1_clr | ack_ie1_c));
      else       ie1_q <= ~pin1_s;
    end
  end

  assign flags = {i_ri | i_ti, i_tf1, ie1_q, i_tf0, ie0_q};

  // A source must outrank whatever is in service: high blocks all, low blocks low
  always_comb begin
    lvl_mask = '1;
    if (ins_q[1])      lvl_mask = '0;
    else if (ins_q[0]) lvl_mask = i_ip[NSRC-1:0];
  end

  assign req_ok  = {NSRC{i_ie[7]}} & i_ie[NSRC-1:0] & flags & lvl_mask;
  assign req_hi  = req_ok & i_ip[NSRC-1:0];
  assign req_lo  = req_ok & ~i_ip[NSRC-1:0];
  assign pick    = (|req_hi) ? req_hi : req_lo;
  assign any_req = |req_ok;

  always_comb begin
    win_idx = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (pick[i]) win_idx = IDX_W'(i);
    end
  end

  assign win_vec = 16'(VEC_BASE + 16'(win_idx) * VEC_STRIDE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      irq_q     <= 1'b0;
      vec_q     <= '0;
      idx_q     <= '0;
      ins_q     <= '0;
      tf0_clr_q <= 1'b0;
      tf1_clr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      irq_q     <= irq_d;
      vec_q     <= vec_d;
      idx_q     <= idx_d;
      ins_q     <= ins_d;
      tf0_clr_q <= tf0_clr_d;
      tf1_clr_q <= tf1_clr_d;
    end
  end

  // Next state; RETI clear is applied before the ACK set
  always_comb begin
    state_d   = state_q;
    irq_d     = irq_q;
    vec_d     = vec_q;
    idx_d     = idx_q;
    tf0_clr_d = 1'b0;
    tf1_clr_d = 1'b0;
    ack_ie0_c = 1'b0;
    ack_ie1_c = 1'b0;

    ins_ret = ins_q;
    if (i_reti) begin
      if (ins_q[1]) ins_ret[1] = 1'b0;
      else          ins_ret[0] = 1'b0;
    end
    ins_d = ins_ret;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = REQ;
          irq_d   = 1'b1;
          vec_d   = win_vec;
          idx_d   = win_idx;
        end
      end
      REQ: begin
        if (i_ack) begin
          ins_d   = ins_ret | (i_ip[idx_q] ? 2'b10 : 2'b01);
          irq_d   = 1'b0;
          state_d = IDLE;
          case (idx_q)
            3'd0:    ack_ie0_c = 1'b1;
            3'd1:    tf0_clr_d = 1'b1;
            3'd2:    ack_ie1_c = 1'b1;
            3'd3:    tf1_clr_d = 1'b1;
            default: ;
          endcase
        end else if (!any_req) begin
          irq_d   = 1'b0;
          state_d = IDLE;
        end else begin
          vec_d = win_vec;
          idx_d = win_idx;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_irq        = irq_q;
  assign o_vector     = vec_q;
  assign o_ie0        = ie0_q;
  assign o_ie1        = ie1_q;
  assign o_tf0_clr    = tf0_clr_q;
  assign o_tf1_clr    = tf1_clr_q;
  assign o_in_service = ins_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: arbitration table plus
// multi-cycle sequences for pin timing, preemption, RETI and reset.
module tb_interrupt_controller;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic [7:0]  i_ie, i_ip;
  logic        i_it0, i_it1, i_int0_n, i_int1_n;
  logic        i_ie0_clr, i_ie1_clr;
  logic        i_tf0, i_tf1, i_ri, i_ti, i_ack, i_reti;
  logic        o_irq;
  logic [15:0] o_vector;
  logic        o_ie0, o_ie1, o_tf0_clr, o_tf1_clr;
  logic [1:0]  o_in_service;

  int checks   = 0;
  int failures = 0;

  interrupt_controller dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_ie(i_ie), .i_ip(i_ip),
    .i_it0(i_it0), .i_it1(i_it1), .i_int0_n(i_int0_n), .i_int1_n(i_int1_n),
    .i_ie0_clr(i_ie0_clr), .i_ie1_clr(i_ie1_clr), .i_tf0(i_tf0), .i_tf1(i_tf1),
    .i_ri(i_ri), .i_ti(i_ti), .i_ack(i_ack), .i_reti(i_reti),
    .o_irq(o_irq), .o_vector(o_vector), .o_ie0(o_ie0), .o_ie1(o_ie1),
    .o_tf0_clr(o_tf0_clr), .o_tf1_clr(o_tf1_clr), .o_in_service(o_in_service)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [7:0]  ie;
    logic [7:0]  ip;
    logic        tf0, tf1, ri, ti;
    logic        irq;
    logic [15:0] vec;
  } row_t;

  row_t tbl [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic pulse_ack();
    i_ack = 1'b1; tick(); i_ack = 1'b0;
  endtask

  task automatic pulse_reti();
    i_reti = 1'b1; tick(); i_reti = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0] = '{8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
    tbl[1] = '{8'h02, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
    tbl[2] = '{8'h82, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h000B};
    tbl[3] = '{8'h9E, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h001B};
    tbl[4] = '{8'h9E, 8'h10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0023};
    tbl[5] = '{8'h9E, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0023};
    tbl[6] = '{8'h9A, 8'h08, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h001B};
    tbl[7] = '{8'h9A, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h000B};
    tbl[8] = '{8'h9A, 8'h0A, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h000B};
    tbl[9] = '{8'h18, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000};

    i_rst_n = 1'b0; i_ie = 8'h00; i_ip = 8'h00; i_it0 = 1'b1; i_it1 = 1'b1;
    i_int0_n = 1'b1; i_int1_n = 1'b1; i_ie0_clr = 1'b0; i_ie1_clr = 1'b0;
    i_tf0 = 1'b0; i_tf1 = 1'b0; i_ri = 1'b0; i_ti = 1'b0; i_ack = 1'b0; i_reti = 1'b0;
    tick(2);
    check("reset_irq", 32'(o_irq), 32'd0);
    check("reset_vec", 32'(o_vector), 32'd0);
    check("reset_ins", 32'(o_in_service), 32'd0);
    check("reset_ie0ie1", 32'({o_ie0, o_ie1}), 32'd0);
    check("reset_clr", 32'({o_tf0_clr, o_tf1_clr}), 32'd0);
    i_rst_n = 1'b1;
    tick();

    // Arbitration table: masking, levels and natural-order ties
    for (int k = 0; k < 10; k++) begin
      i_ie = tbl[k].ie; i_ip = tbl[k].ip;
      i_tf0 = tbl[k].tf0; i_tf1 = tbl[k].tf1; i_ri = tbl[k].ri; i_ti = tbl[k].ti;
      tick(2);
      check($sformatf("tbl%0d_irq", k), 32'(o_irq), 32'(tbl[k].irq));
      if (tbl[k].irq) check($sformatf("tbl%0d_vec", k), 32'(o_vector), 32'(tbl[k].vec));
    end
    i_ie = 8'h00; i_ip = 8'h00; i_tf0 = 1'b0; i_tf1 = 1'b0; i_ri = 1'b0; i_ti = 1'b0;
    tick(2);
    check("idle_after_tbl", 32'(o_irq), 32'd0);

    // Pin timing, edge mode on INT0
    i_it0 = 1'b1; i_ie = 8'h81; i_ip = 8'h00;
    i_int0_n = 1'b0;
    tick(2);
    check("pin_ie0_early", 32'(o_ie0), 32'd0);
    tick();
    check("pin_ie0_set", 32'(o_ie0), 32'd1);
    check("pin_irq_early", 32'(o_irq), 32'd0);
    tick();
    check("pin_irq", 32'(o_irq), 32'd1);
    check("pin_vec", 32'(o_vector), 32'h0003);
    pulse_ack();
    check("pin_ack_ie0", 32'(o_ie0), 32'd0);
    check("pin_ack_ins", 32'(o_in_service), 32'd1);
    check("pin_ack_irq", 32'(o_irq), 32'd0);
    i_int0_n = 1'b1;
    pulse_reti();
    check("pin_reti_ins", 32'(o_in_service), 32'd0);
    i_ie = 8'h00;
    tick();

    // Preemption of low-level TF0 by high-level TF1
    i_ie = 8'h8A; i_ip = 8'h08; i_tf0 = 1'b1;
    tick();
    check("pre_irq0", 32'(o_irq), 32'd1);
    check("pre_vec0", 32'(o_vector), 32'h000B);
    pulse_ack();
    check("pre_tf0_clr", 32'(o_tf0_clr), 32'd1);
    check("pre_ins0", 32'(o_in_service), 32'd1);
    i_tf0 = 1'b0;
    tick();
    check("pre_tf0_clr_end", 32'(o_tf0_clr), 32'd0);
    i_tf1 = 1'b1;
    tick();
    check("pre_irq1", 32'(o_irq), 32'd1);
    check("pre_vec1", 32'(o_vector), 32'h001B);
    pulse_ack();
    check("pre_tf1_clr", 32'(o_tf1_clr), 32'd1);
    check("pre_ins1", 32'(o_in_service), 32'd3);
    check("pre_irq_drop", 32'(o_irq), 32'd0);
    i_tf1 = 1'b0;
    tick();
    check("pre_tf1_clr_end", 32'(o_tf1_clr), 32'd0);

    // RETI ordering
    pulse_reti();
    check("reti_1", 32'(o_in_service), 32'd1);
    pulse_reti();
    check("reti_2", 32'(o_in_service), 32'd0);
    pulse_reti();
    check("reti_none", 32'(o_in_service), 32'd0);

    // Tie at equal level, then retraction by dropping EA
    i_ie = 8'h07; i_ip = 8'h00; i_it1 = 1'b1; i_tf0 = 1'b1; i_int1_n = 1'b0;
    tick(4);
    check("tie_ie1", 32'(o_ie1), 32'd1);
    check("tie_noirq", 32'(o_irq), 32'd0);
    i_ie = 8'h87;
    tick();
    check("tie_irq", 32'(o_irq), 32'd1);
    check("tie_vec", 32'(o_vector), 32'h000B);
    i_ie = 8'h07;
    tick();
    check("ret_irq", 32'(o_irq), 32'd0);
    check("ret_clr", 32'({o_tf0_clr, o_tf1_clr}), 32'd0);
    check("ret_ie1", 32'(o_ie1), 32'd1);
    check("ret_ins", 32'(o_in_service), 32'd0);
    i_tf0 = 1'b0; i_int1_n = 1'b1; i_ie1_clr = 1'b1;
    tick();
    i_ie1_clr = 1'b0;
    check("sw_clr_ie1", 32'(o_ie1), 32'd0);
    tick(3);

    // Level mode INT1: ACK does not clear, RETI re-enables request
    i_it1 = 1'b0; i_ie = 8'h84; i_ip = 8'h00; i_int1_n = 1'b0;
    tick(3);
    check("lvl_ie1", 32'(o_ie1), 32'd1);
    tick();
    check("lvl_irq", 32'(o_irq), 32'd1);
    check("lvl_vec", 32'(o_vector), 32'h0013);
    pulse_ack();
    check("lvl_ack_ie1", 32'(o_ie1), 32'd1);
    check("lvl_ack_ins", 32'(o_in_service), 32'd1);
    tick();
    check("lvl_blocked", 32'(o_irq), 32'd0);
    pulse_reti();
    check("lvl_reti_ins", 32'(o_in_service), 32'd0);
    tick();
    check("lvl_reirq", 32'(o_irq), 32'd1);
    check("lvl_revec", 32'(o_vector), 32'h0013);

    // Asynchronous reset mid-REQ
    #2;
    i_rst_n = 1'b0;
    #1;
    check("arst_irq", 32'(o_irq), 32'd0);
    check("arst_ins", 32'(o_in_service), 32'd0);
    check("arst_ie", 32'({o_ie0, o_ie1}), 32'd0);
    i_int1_n = 1'b1;
    tick();
    i_rst_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- 8051 interrupt controller: the consumer of the timer overflow flags (TF0/TF1), external INT0/INT1 pins and serial RI/TI.
- Applies IE/IP masking and the two-level priority scheme, then raises a vectored request to the CPU core.
- Tracks in-service levels until RETI.
- Returns hardware flag-clear pulses to the TCON SFR logic.

Parameters:
- SYNC_STAGES, 2, synchronizer depth on INT0/INT1 pins (min 2)
- VEC_BASE, 16'h0003, vector of highest-natural-priority source (IE0)
- VEC_STRIDE, 16'h0008, address step between consecutive vectors

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_ie  in  8  IE SFR: [7]=EA, [4]=ES, [3]=ET1, [2]=EX1, [1]=ET0, [0]=EX0
- i_ip  in  8  IP SFR: [4]=PS, [3]=PT1, [2]=PX1, [1]=PT0, [0]=PX0 (1 = high)
- i_it0  in  1  TCON.IT0: 1 = falling-edge, 0 = low-level
- i_it1  in  1  TCON.IT1: same for INT1
- i_int0_n  in  1  external INT0 pin, async
- i_int1_n  in  1  external INT1 pin, async
- i_ie0_clr  in  1  software clear pulse for IE0 (TCON write)
- i_ie1_clr  in  1  software clear pulse for IE1
- i_tf0  in  1  timer 0 overflow flag
- i_tf1  in  1  timer 1 overflow flag
- i_ri  in  1  serial receive flag
- i_ti  in  1  serial transmit flag
- i_ack  in  1  CPU accepted vector (LCALL issued), 1-cycle pulse
- i_reti  in  1  CPU executed RETI, 1-cycle pulse
- o_irq  out  1  interrupt request to CPU
- o_vector  out  16  vector address, valid while o_irq=1
- o_ie0  out  1  IE0 flag (to TCON[1])
- o_ie1  out  1  IE1 flag (to TCON[3])
- o_tf0_clr  out  1  1-cycle pulse: clear TF0
- o_tf1_clr  out  1  1-cycle pulse: clear TF1
- o_in_service  out  2  [1]=high level active, [0]=low level active

Behaviour:
Reset (i_rst_n=0, async):
- All outputs and state are 0; synchronizer flops are set to 1 (pins idle high).
- FSM enters IDLE.

Pin path:
- SYNC_STAGES flops, then an edge register.
- Edge mode: synchronized 1->0 transition sets IE0 next cycle. Pin fall to o_ie0=1 is SYNC_STAGES+1 cycles.
- Level mode: o_ie0 = registered inverse of the synchronized pin.
- i_ie0_clr clears IE0 in edge mode. A set and a clear in the same cycle: set wins. Same rules for INT1.

Sources, in natural order:
- IE0 (vec 0003), TF0 (000B), IE1 (0013), TF1 (001B), SER = RI|TI (0023).
- vector = VEC_BASE + idx*VEC_STRIDE.

Eligibility:
- A source is eligible when EA=1, its enable bit is 1 and its flag is 1.
- Its level L is given by the matching IP bit.
- It may be requested only if L > current in-service level. Nothing in service counts as level -1, so a high-level source can preempt a low-level one; nothing preempts a high-level one.

Arbitration:
- Highest eligible level wins; ties go to natural order.

FSM IDLE:
- If any source is requestable, go to REQ and register o_irq=1 with the vector.
- Flag to o_irq latency is 1 cycle.

FSM REQ:
- Re-arbitrates every cycle, so o_vector may change to a newly arrived higher source.
- No requestable source (flag cleared, EA dropped) -> o_irq=0, back to IDLE.
- i_ack -> set in_service[L] for the source currently presented.
  - Source IE0/IE1 in edge mode: clear it.
  - Source TF0/TF1: pulse o_tfx_clr for that timer in the same cycle.
  - RI/TI are never cleared by hardware.
  - o_irq=0 next cycle, go to IDLE.

i_reti:
- Clears in_service[1] if set, else in_service[0]. With nothing in service it has no effect.
- When RETI and ACK land in the same cycle, the clear is applied first, then the ACK set.

Extra pulses:
- i_ack while in IDLE is ignored.
- After any ACK, at least one IDLE cycle passes before o_irq can reassert.

Test Plan:
- Pin timing: IT0=1, IE=8'h81, IP=0, fall i_int0_n -> o_ie0=1 after 3 cycles, o_irq=1 with o_vector=16'h0003 one cycle later. After i_ack: o_ie0=0, o_in_service=2'b01.
- Preemption: TF0=1, IE=8'h8A, IP=8'h08 (TF1 high), ACK TF0; then TF1=1 -> o_irq=1, vector 001B (preempts). After ACK: o_tf1_clr pulses one cycle, o_in_service=2'b11.
- RETI ordering: two i_reti pulses -> o_in_service goes 2'b11 -> 2'b01 -> 2'b00.
- Tie and retraction: TF0 and IE1 both pending at the same level, IE=8'h87 -> vector 000B. Drop EA before ACK -> o_irq=0 next cycle, no clear pulses.
- Level mode: IT1=0, hold i_int1_n low, ACK -> IE1 not cleared. RETI -> o_irq reasserts with 0013.
- Async reset: assert i_rst_n=0 mid-REQ -> o_irq, o_in_service, o_ie0 and o_ie1 are 0 immediately, without waiting for a clock.
